result_writeback: RTL and testbench

- Consumer end of the execution-unit output handshake (output_valid / output_ready, rs_id_out, result_reg_addr_out, result, cr0_xer).
- Collects completed results from NUM_UNITS execution units, such as the logical and add/sub units, using round-robin arbitration.
- Derives the CR0 field and the XER updates from each accepted result.
- Presents one registered writeback per cycle to the register file and reservation-station release logic, with its own valid/ready handshake.

---
 rtl/result_writeback_pkg.sv | 49 ++++
 rtl/result_writeback_rr_arbiter.sv | 50 +++++
 rtl/result_writeback.sv | 136 +++++++++++++
 tb/tb_result_writeback.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/result_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_writeback_pkg
// Description : Shared types for the result writeback stage: condition /
//               exception flags, the CR0 field and the writeback record.
// Revision    : 1.0 - initial release
// ============================================================================
package result_writeback_pkg;

    localparam int c_RS_ID_W    = 5;
    localparam int c_REG_ADDR_W = 5;
    localparam int c_DATA_W     = 32;

    typedef struct packed {
        logic cr0_valid;
        logic ov;
        logic ov_valid;
        logic ca;
        logic ca_valid;
    } cond_exception_t;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic so;
    } cr0_t;

    typedef struct packed {
        logic [c_RS_ID_W-1:0]    rs_id;
        logic [c_REG_ADDR_W-1:0] reg_addr;
        logic [0:c_DATA_W-1]     data;
        logic                    cr0_we;
        cr0_t                    cr0;
        cond_exception_t         xer;
    } wb_record_t;

    // Bit 0 of the result word is the sign bit.
    function automatic cr0_t calc_cr0(input logic [0:c_DATA_W-1] r, input logic so);
        cr0_t c;
        c.lt = r[0];
        c.eq = (r == '0);
        c.gt = ~r[0] & (r != '0);
        c.so = so;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_writeback_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : result_writeback_rr_arbiter
// Description : Round-robin arbiter; searches upward from the pointer with
//               wrap-around and moves the pointer past the winner on advance.
// Revision    : 1.0 - initial release
// ============================================================================
module result_writeback_rr_arbiter
    import result_writeback_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [0:NUM_REQ-1] req,
    input  logic               advance,
    output logic [0:NUM_REQ-1] grant,
    output logic [c_IDX_W-1:0] grant_idx
);

    logic [c_IDX_W-1:0] r_ptr;
    logic               w_found;
    int                 w_cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = (int'(r_ptr) + i) % NUM_REQ;
            if (!w_found && req[c_IDX_W'(w_cand)]) begin
                w_found                  = 1'b1;
                grant[c_IDX_W'(w_cand)]  = 1'b1;
                grant_idx                = c_IDX_W'(w_cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (grant_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_writeback.sv
`default_nettype none
// ============================================================================
// Module      : result_writeback
// Description : Round-robin collector of execution-unit results; derives CR0
//               and XER updates and presents one registered writeback record.
//               Optional macro WB_SKID_BUFFER_EN adds a 1-entry skid register.
// Revision    : 1.0 - initial release
// ============================================================================
module result_writeback
    import result_writeback_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [0:NUM_UNITS-1]   unit_valid,
    output logic [0:NUM_UNITS-1]   unit_ready,
    input  logic [RS_ID_WIDTH-1:0] unit_rs_id    [NUM_UNITS],
    input  logic [4:0]             unit_reg_addr [NUM_UNITS],
    input  logic [0:31]            unit_result   [NUM_UNITS],
    input  cond_exception_t        unit_cr0_xer  [NUM_UNITS],
    input  logic                   xer_so,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [RS_ID_WIDTH-1:0] wb_rs_id,
    output logic [4:0]             wb_reg_addr,
    output logic [0:31]            wb_data,
    output logic                   wb_cr0_we,
    output cr0_t                   wb_cr0,
    output cond_exception_t        wb_xer
);

    localparam int c_IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic                 w_stage_en;
    logic                 w_arb_en;
    logic                 w_held_ov;
    logic                 w_transfer;
    logic                 w_so_eff;
    logic [0:NUM_UNITS-1] w_req;
    logic [0:NUM_UNITS-1] w_grant;
    logic [c_IDX_W-1:0]   w_grant_idx;
    wb_record_t           w_rec;
    wb_record_t           r_wb;
    logic                 r_wb_valid;

    assign w_stage_en = ~r_wb_valid | wb_ready;

`ifdef WB_SKID_BUFFER_EN
    wb_record_t r_skid;
    logic       r_skid_valid;

    // Ready depends only on skid occupancy, never on wb_ready.
    assign w_arb_en  = ~r_skid_valid;
    assign w_held_ov = (r_wb_valid & r_wb.xer.ov_valid & r_wb.xer.ov)
                     | (r_skid_valid & r_skid.xer.ov_valid & r_skid.xer.ov);
`else
    assign w_arb_en  = w_stage_en;
    assign w_held_ov = r_wb_valid & r_wb.xer.ov_valid & r_wb.xer.ov;
`endif

    assign w_req      = unit_valid & {NUM_UNITS{w_arb_en & rst}};
    assign unit_ready = w_grant;
    assign w_transfer = |(unit_valid & w_grant);

    result_writeback_rr_arbiter #(
        .NUM_REQ   (NUM_UNITS)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (w_req),
        .advance   (w_transfer),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // The record being accepted; SO also sees an OV still waiting to reach XER.
    always_comb begin
        w_rec          = '0;
        w_rec.rs_id    = c_RS_ID_W'(unit_rs_id[w_grant_idx]);
        w_rec.reg_addr = unit_reg_addr[w_grant_idx];
        w_rec.data     = unit_result[w_grant_idx];
        w_rec.xer      = unit_cr0_xer[w_grant_idx];
        w_rec.cr0_we   = w_rec.xer.cr0_valid;
        w_so_eff       = xer_so | (w_rec.xer.ov_valid & w_rec.xer.ov) | w_held_ov;
        w_rec.cr0      = calc_cr0(w_rec.data, w_so_eff);
    end

`ifdef WB_SKID_BUFFER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid   <= 1'b0;
            r_wb         <= '0;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
        end else if (w_stage_en) begin
            if (r_skid_valid) begin
                r_wb         <= r_skid;
                r_wb_valid   <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_transfer) begin
                r_wb       <= w_rec;
                r_wb_valid <= 1'b1;
            end else begin
                r_wb_valid <= 1'b0;
            end
        end else if (w_transfer) begin
            r_skid       <= w_rec;
            r_skid_valid <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid <= 1'b0;
            r_wb       <= '0;
        end else if (w_transfer) begin
            r_wb       <= w_rec;
            r_wb_valid <= 1'b1;
        end else if (w_stage_en) begin
            r_wb_valid <= 1'b0;
        end
    end
`endif

    assign wb_valid    = r_wb_valid;
    assign wb_rs_id    = RS_ID_WIDTH'(r_wb.rs_id);
    assign wb_reg_addr = r_wb.reg_addr;
    assign wb_data     = r_wb.data;
    assign wb_cr0_we   = r_wb.cr0_we;
    assign wb_cr0      = r_wb.cr0;
    assign wb_xer      = r_wb.xer;

endmodule
`default_nettype wire

// File: tb/tb_result_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_writeback
// Description : Directed self-checking bench for result_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_writeback;
    import result_writeback_pkg::*;

    localparam int c_N  = 4;
    localparam int c_RW = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [0:c_N-1]        unit_valid;
    logic [0:c_N-1]        unit_ready;
    logic [c_RW-1:0]       unit_rs_id    [c_N];
    logic [4:0]            unit_reg_addr [c_N];
    logic [0:31]           unit_result   [c_N];
    cond_exception_t       unit_cr0_xer  [c_N];
    logic                  xer_so;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [c_RW-1:0]       wb_rs_id;
    logic [4:0]            wb_reg_addr;
    logic [0:31]           wb_data;
    logic                  wb_cr0_we;
    cr0_t                  wb_cr0;
    cond_exception_t       wb_xer;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    result_writeback #(
        .NUM_UNITS     (c_N),
        .RS_ID_WIDTH   (c_RW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .unit_valid    (unit_valid),
        .unit_ready    (unit_ready),
        .unit_rs_id    (unit_rs_id),
        .unit_reg_addr (unit_reg_addr),
        .unit_result   (unit_result),
        .unit_cr0_xer  (unit_cr0_xer),
        .xer_so        (xer_so),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_rs_id      (wb_rs_id),
        .wb_reg_addr   (wb_reg_addr),
        .wb_data       (wb_data),
        .wb_cr0_we     (wb_cr0_we),
        .wb_cr0        (wb_cr0),
        .wb_xer        (wb_xer)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int i, input logic [31:0] r, input cond_exception_t f);
        unit_result[i]  = r;
        unit_cr0_xer[i] = f;
    endtask

    cond_exception_t f_none, f_cr0, f_ov;
    logic [0:c_N-1]  exp_rdy;
    int              g;

    initial begin
        f_none = '0;
        f_cr0  = '0;  f_cr0.cr0_valid = 1'b1;
        f_ov   = f_cr0; f_ov.ov = 1'b1; f_ov.ov_valid = 1'b1;

        rst      = 1'b0;
        wb_ready = 1'b1;
        xer_so   = 1'b0;
        for (int i = 0; i < c_N; i++) begin
            unit_rs_id[i]    = c_RW'(10 + i);
            unit_reg_addr[i] = 5'(i + 1);
            set_unit(i, 32'h0, f_none);
        end
        unit_valid = '1;

        // Reset state
        #12;
        check_eq("rst_wb_valid", 64'(wb_valid), 64'h0);
        check_eq("rst_wb_data", 64'(wb_data), 64'h0);
        check_eq("rst_wb_cr0", 64'(wb_cr0), 64'h0);
        check_eq("rst_wb_xer", 64'(wb_xer), 64'h0);
        check_eq("rst_wb_rs_id", 64'(wb_rs_id), 64'h0);
        check_eq("rst_unit_ready", 64'(unit_ready), 64'h0);
        unit_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single unit 2, negative result
        set_unit(2, 32'hFFFF_FFF0, f_cr0);
        unit_valid = 4'b0010;
        #1;
        check_eq("t1_ready", 64'(unit_ready), 64'(4'b0010));
        tick();
        unit_valid = '0;
        check_eq("t1_wb_valid", 64'(wb_valid), 64'h1);
        check_eq("t1_wb_data", 64'(wb_data), 64'hFFFF_FFF0);
        check_eq("t1_wb_cr0", 64'(wb_cr0), 64'(4'b1000));
        check_eq("t1_wb_cr0_we", 64'(wb_cr0_we), 64'h1);
        check_eq("t1_wb_rs_id", 64'(wb_rs_id), 64'd12);
        check_eq("t1_wb_reg_addr", 64'(wb_reg_addr), 64'd3);
        tick();
        check_eq("t1_idle_valid", 64'(wb_valid), 64'h0);

        // Move pointer to 1 via unit 0, then all units valid
        set_unit(2, 32'h0, f_none);
        unit_valid = 4'b1000;
        tick();
        check_eq("t2_pre_rs_id", 64'(wb_rs_id), 64'd10);
        unit_valid = '1;
        for (int k = 0; k < 5; k++) begin
            g = (1 + k) % c_N;
            exp_rdy    = '0;
            exp_rdy[g] = 1'b1;
            #1;
            check_eq($sformatf("t2_ready_%0d", k), 64'(unit_ready), 64'(exp_rdy));
            tick();
            check_eq($sformatf("t2_rs_id_%0d", k), 64'(wb_rs_id), 64'(10 + g));
        end
        unit_valid = '0;

        // OV result then plain result: SO forwarded from held record
        set_unit(0, 32'h0, f_ov);
        unit_valid = 4'b1000;
        tick();
        check_eq("t3_cr0_a", 64'(wb_cr0), 64'(4'b0011));
        check_eq("t3_xer_a", 64'(wb_xer), 64'(f_ov));
        set_unit(0, 32'h5, f_cr0);
        tick();
        check_eq("t3_cr0_b", 64'(wb_cr0), 64'(4'b0101));
        unit_valid = '0;
        tick();
        unit_valid = 4'b1000;
        tick();
        unit_valid = '0;
        check_eq("t3_cr0_c", 64'(wb_cr0), 64'(4'b0100));
        tick();

`ifdef WB_SKID_BUFFER_EN
        // Pointer 1 here; transfer during wb_ready low lands in skid
        unit_valid = 4'b1000;
        tick();
        wb_ready   = 1'b0;
        unit_valid = 4'b0100;
        #1;
        check_eq("sk_ready_empty", 64'(unit_ready), 64'(4'b0100));
        tick();
        unit_valid = 4'b0010;
        #1;
        check_eq("sk_ready_full", 64'(unit_ready), 64'h0);
        check_eq("sk_hold_rs_a", 64'(wb_rs_id), 64'd10);
        tick();
        check_eq("sk_hold_rs_b", 64'(wb_rs_id), 64'd10);
        wb_ready = 1'b1;
        #1;
        check_eq("sk_ready_drain", 64'(unit_ready), 64'h0);
        tick();
        check_eq("sk_out_rs", 64'(wb_rs_id), 64'd11);
        #1;
        check_eq("sk_ready_regrant", 64'(unit_ready), 64'(4'b0010));
        tick();
        check_eq("sk_next_rs", 64'(wb_rs_id), 64'd12);
        unit_valid = '0;
`else
        // Held record with wb_ready low for 3 cycles (pointer 1 -> unit 3 wins)
        set_unit(3, 32'h1234, f_cr0);
        unit_valid = 4'b0001;
        tick();
        check_eq("t4_data", 64'(wb_data), 64'h1234);
        wb_ready   = 1'b0;
        unit_valid = '1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("t4_ready_%0d", k), 64'(unit_ready), 64'h0);
            tick();
            check_eq($sformatf("t4_data_%0d", k), 64'(wb_data), 64'h1234);
            check_eq($sformatf("t4_valid_%0d", k), 64'(wb_valid), 64'h1);
        end
        wb_ready = 1'b1;
        #1;
        check_eq("t4_regrant", 64'(unit_ready), 64'(4'b1000));
        tick();
        check_eq("t4_rs_after", 64'(wb_rs_id), 64'd10);
        unit_valid = '0;
`endif

        // Asynchronous reset while a record is held
        check_eq("t5_pre_valid", 64'(wb_valid), 64'h1);
        #1;
        rst = 1'b0;
        #1;
        check_eq("t5_async_valid", 64'(wb_valid), 64'h0);
        unit_valid = 4'b0101;
        #1;
        check_eq("t5_rst_ready", 64'(unit_ready), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t5_first_grant", 64'(unit_ready), 64'(4'b0100));
        tick();
        check_eq("t5_rs_id", 64'(wb_rs_id), 64'd11);
        unit_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
